regfile_sequencer: RTL
======================

Name: regfile_sequencer

Overview:
- Multi-cycle operand-fetch/execute/write-back sequencer that drives the 8x16 register file's read and write ports.
- Accepts one decoded ALU instruction per start pulse.
- Reads Rn into A and Rm into B through the register file's combinational read port, then shifts B and computes the result into C. It writes C back to Rd and pulses done.
- Sits between the instruction decoder upstream and the register file, and owns the A/B/C registers and the status flags.

Parameters:
- DATA_W, 16: datapath and register width; must match the register file word.
- IMM_W, 8: immediate field width; sign-extended to DATA_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  3  000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 110/111 NOP
- shift  in  2  B-operand shift: 00 none, 01 LSL1 (0 fill), 10 LSR1 (0 fill), 11 ASR1 (MSB fill)
- rn, rd, rm  in  3 each  register indices
- imm  in  IMM_W  immediate for MOVI
- reg_data  in  DATA_W  register-file read data for the current readnum
- readnum  out  3  register-file read select
- writenum  out  3  register-file write select
- write  out  1  register-file write enable
- data_in  out  DATA_W  register-file write data; always equals C
- c_out  out  DATA_W  C register
- status  out  3  {N, V, Z}
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse on completion

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, taking effect only at the rising edge of clk.
- Reset values: state IDLE; A, B and C are 0; status 000; done 0; write 0; busy 0; captured fields 0.
- readnum and writenum reset to 0. readnum = rn in LOAD_A, rm in LOAD_B, otherwise 0.
- write is decoded from state and is high only in WRITE, where writenum = captured rd.
- Fields are captured at the edge where IDLE sees start=1.
- Later changes to op, shift, rn, rd, rm or imm do not affect the operation in flight.
- Paths (one state per cycle):
  - ADD/AND/CMP: IDLE, LOAD_A, LOAD_B, EXEC, then WRITE (CMP skips WRITE), then IDLE.
  - MOV/MVN: IDLE, LOAD_B, EXEC, WRITE, IDLE.
  - MOVI: IDLE, EXEC, WRITE, IDLE.
  - NOP: IDLE, EXEC, IDLE.
- Operand capture: LOAD_A captures A = reg_data at the end of the cycle. LOAD_B captures B = reg_data.
- EXEC: Bsh = shift(B). C gets:
  - ADD: A+Bsh, truncated to DATA_W.
  - AND: A&Bsh.
  - MOV: Bsh.
  - MVN: ~Bsh.
  - MOVI: sign-extended imm.
  - CMP and NOP: C unchanged.
- Status is updated only in EXEC of CMP, from D = A-Bsh (mod 2^DATA_W):
  - Z = (D==0).
  - N = D[MSB].
  - V = (A[MSB]!=Bsh[MSB]) && (D[MSB]!=A[MSB]).
- Other ops leave status unchanged.
- done: registered; high for exactly the first IDLE cycle after the last working state; otherwise 0.
- Latency, with start sampled at edge 0:
  - done high in cycle 5 for ADD/AND, 4 for CMP/MOV/MVN, 3 for MOVI, 2 for NOP.
- Register-file update: the write lands at the WRITE-exit edge, so the new Rd value is readable in the done cycle.
- start while busy: ignored, no queuing.
- start in the done cycle: accepted; back-to-back operations are legal.
- Register aliasing: rd may equal rn or rm. Operands are captured before WRITE, so there is no hazard.
- rn == rm: allowed; the register is read twice.
- Reset mid-operation: return to IDLE at that edge, and write=0 from the next cycle on.
  - A register-file write in progress only completes if the reset edge is the WRITE-exit edge, since the regfile samples write at the same edge.
  - No done pulse is generated for the aborted operation.
- Unused encodings 110/111: NOP; status, C and the register file are unchanged.

Test Plan:
- Reset, then MOVI rd=3 imm=8'hF6 -> write=1 in cycle 2 with writenum=3 and data_in=16'hFFF6; done in cycle 3; status stays 000.
- R1=16'h0005, R2=16'h0003; ADD rd=4 rn=1 rm=2 shift=01 -> data_in=16'h000B in WRITE (cycle 4); done in cycle 5; R4=16'h000B.
- CMP with R1=16'h7FFF, R2=16'hFFFF, shift=00 -> status {N,V,Z}=110; write never asserted; done in cycle 4.
- CMP with R1=R2=16'h1234 -> Z=1, N=0, V=0.
- MVN rd=rm=5, R5=16'h8000, shift=11 -> B=16'hC000; R5 becomes 16'h3FFF.
- start re-pulsed during busy -> ignored, exactly one done.
- start in the done cycle -> second operation completes.
- reset asserted during LOAD_B of an ADD -> write never asserted, no done pulse; A, B, C and status return to 0 and busy falls after the reset edge.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Operand-fetch / execute / write-back sequencer in front of an 8x16 register file.
// Owns the A/B/C datapath registers and the {N,V,Z} status flags.
module regfile_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [1:0]        shift,
  input  logic [2:0]        rn,
  input  logic [2:0]        rd,
  input  logic [2:0]        rm,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] reg_data,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] c_out,
  output logic [2:0]        status,
  output logic              busy,
  output logic              done
);

  localparam int unsigned REG_W = 3;
  localparam int unsigned EXT_W = DATA_W - IMM_W;

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVN  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          shift_q, shift_d;
  logic [REG_W-1:0]    rn_q, rn_d, rd_q, rd_d, rm_q, rm_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]          status_q, status_d;
  logic [REG_W-1:0]    readnum_q, readnum_d, writenum_q, writenum_d;
  logic                write_q, write_d, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0]   bsh, diff;

  // State and datapath registers; reset is synchronous
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      shift_q    <= '0;
      rn_q       <= '0;
      rd_q       <= '0;
      rm_q       <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      status_q   <= '0;
      readnum_q  <= '0;
      writenum_q <= '0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      shift_q    <= shift_d;
      rn_q       <= rn_d;
      rd_q       <= rd_d;
      rm_q       <= rm_d;
      imm_q      <= imm_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      status_q   <= status_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state, field capture, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    shift_d    = shift_q;
    rn_d       = rn_q;
    rd_d       = rd_q;
    rm_d       = rm_q;
    imm_d      = imm_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    status_d   = status_q;
    bsh        = b_q;
    diff       = a_q - bsh;

    // B-operand shifter
    case (shift_q)
      2'b01:   bsh = {b_q[DATA_W-2:0], 1'b0};
      2'b10:   bsh = {1'b0, b_q[DATA_W-1:1]};
      2'b11:   bsh = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: bsh = b_q;
    endcase
    diff = a_q - bsh;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          shift_d = shift;
          rn_d    = rn;
          rd_d    = rd;
          rm_d    = rm;
          imm_d   = imm;
          case (op)
            OP_ADD, OP_CMP, OP_AND: state_d = S_LOAD_A;
            OP_MOV, OP_MVN:         state_d = S_LOAD_B;
            default:                state_d = S_EXEC;
          endcase
        end
      end
      S_LOAD_A: begin
        a_d     = reg_data;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        b_d     = reg_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WRITE;
        case (op_q)
          OP_MOVI: c_d = {{EXT_W{imm_q[IMM_W-1]}}, imm_q};
          OP_MOV:  c_d = bsh;
          OP_ADD:  c_d = a_q + bsh;
          OP_AND:  c_d = a_q & bsh;
          OP_MVN:  c_d = ~bsh;
          OP_CMP: begin
            status_d = {diff[DATA_W-1],
                        (a_q[DATA_W-1] != bsh[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]),
                        diff == '0};
            state_d  = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs registered from the upcoming state so they align with it
    readnum_d  = (state_d == S_LOAD_A) ? rn_d :
                 (state_d == S_LOAD_B) ? rm_d : '0;
    writenum_d = (state_d == S_WRITE) ? rd_d : '0;
    write_d    = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign write    = write_q;
  assign data_in  = c_q;
  assign c_out    = c_q;
  assign status   = status_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
